game_state_engine: RTL
======================

Name: game_state_engine

Overview:
- Sequential game-logic stage directly upstream of the sprite renderer.
- Owns the game state: ship column, bullet position and flight flag, invader formation (20-bit column mask plus row), and the gameplay state.
- Advances once per video frame on a frame-tick strobe.
- All outputs are registered and wire straight into the renderer's same-named inputs.

Parameters:
- SHIP_PERIOD, 4: frames per ship step while a direction button is held.
- BULLET_PERIOD, 2: frames per one-row bullet ascent.
- INVADER_PERIOD, 30: frames per formation step.
- INIT_ARRAY, 20'h0FFF0: formation column mask at start.
- INIT_LINE, 1: formation row at start.
- SHIP_ROW, 13: ship row; formation reaching it means game over.
- SHIP_INIT, 10: ship column at start.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset (0 = reset).
- i_frame_tick  in  1  one-cycle strobe per frame (vsync start); all state updates occur only on this strobe.
- i_left  in  1  debounced level, move ship left.
- i_right  in  1  debounced level, move ship right.
- i_fire  in  1  debounced level, fire / restart.
- o_invaders_array  out  20  formation mask; bit n = column n.
- o_invaders_line  out  4  formation row, 0..14.
- o_ship_x  out  5  ship column, 0..19.
- o_bullet_x  out  5  bullet column.
- o_bullet_y  out  4  bullet row.
- o_bullet_flying  out  1  bullet active.
- o_gameplay  out  2  00 PLAYING, 01 YOU_WIN, 10 GAME_OVER; 11 never driven.

Behaviour:
- Reset (i_reset=0, asynchronous) values:
  - array=INIT_ARRAY, line=INIT_LINE, ship_x=SHIP_INIT.
  - bullet_x=0, bullet_y=0, flying=0, gameplay=PLAYING.
  - direction=right, all frame counters=0, fire_prev=0.
- Registers change only in the i_clk cycle where i_frame_tick=1; outputs are visible the next cycle. Latency from tick to outputs is 1 cycle.
- Each period counter counts ticks 0..P-1 and expires on the tick where it equals P-1, then wraps to 0. Counters run only in PLAYING.
- PLAYING tick, evaluated in this order on pre-tick values:
  1. Hit: flying && bullet_y==line && array[bullet_x]. On a hit, clear that bit and set flying=0. The bullet neither moves nor respawns this tick.
  2. Bullet move, if no hit and flying and the bullet counter expires: at bullet_y==0 set flying=0, otherwise bullet_y-1.
  3. Fire: if flying was 0 at tick start, no hit occurred, and i_fire=1, then bullet_x=ship_x, bullet_y=SHIP_ROW-1, flying=1. Fire is level-sensitive (autofire).
  4. Ship, on ship counter expiry:
     - left only: ship_x-1, saturating at 0.
     - right only: ship_x+1, saturating at 19.
     - both or neither: hold.
     - The ship counter is held at 0 while neither button is pressed.
  5. Formation, on invader counter expiry, using the post-hit array:
     - Direction right and array[19]=0: shift mask toward higher columns (array<<1).
     - Direction right and array[19]=1: line+1, direction becomes left.
     - Direction left mirrors this with array[0] and array>>1.
  6. End conditions:
     - Post-hit array==0 gives YOU_WIN.
     - Otherwise a new line==SHIP_ROW gives GAME_OVER.
     - If both hold on the same tick, YOU_WIN wins.
- YOU_WIN / GAME_OVER:
  - All outputs frozen except o_gameplay, which stays in the end state.
  - fire_prev is updated every tick in every state.
  - Restart on a tick with i_fire=1 && fire_prev=0: all state re-initialised to reset values, gameplay=PLAYING.
  - A held fire from the final shot does not restart the game; it must be released and pressed again.
- Width rules:
  - bullet_x is always a copy of the clamped ship_x, so it never exceeds 19.
  - The line increment is 4-bit and never exceeds SHIP_ROW.
  - Shifts drop nothing, because the edge test precedes any shift.
- Asserting reset mid-frame or mid-flight returns to the reset values immediately; the next tick behaves as the first frame.

Decomposition:
- Shared package game_pkg:
  - gameplay encodings PLAYING/YOU_WIN/GAME_OVER (shared with the renderer);
  - GRID_COLS=20, GRID_ROWS=15, SHIP_ROW, colour constants.
- Sub-module frame_divider, instantiated three times (ship, bullet, invader):
  - parameter PERIOD;
  - inputs i_clk, i_reset, i_frame_tick, i_enable, i_clear;
  - output o_expire;
  - 6-bit counter.

Test Plan:
- Reset check: drive i_reset=0 then 1 -> array=0x0FFF0, line=1, ship_x=10, flying=0, gameplay=00.
- Ship clamp: hold i_left for 60 ticks -> ship_x decrements every 4 ticks and stops at 0. Then hold both buttons for 8 ticks -> ship_x stays 0.
- Bullet launch: ship_x=4, press fire for one tick -> bullet_x=4, bullet_y=12, flying=1, bullet_y decrements every 2 ticks. Force array=0, let it pass row 0 -> flying=0.
- Hit and win:
  - Force array=0x00010, line=5, fire at ship_x=4 -> bit 4 clears on the tick bullet_y==5, flying=0, gameplay=01.
  - Holding fire does not restart; release then press -> full re-init.
- Formation edge: array=0x80000, direction right, expiry -> line+1, mask unchanged. Next expiry -> array=0x40000.
- Game over: line=12 with the mask at the edge, invader expiry -> line=13, gameplay=10. Outputs then freeze for 100 ticks.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game logic and the sprite renderer: grid geometry,
// gameplay encodings and palette.
package game_pkg;

  localparam int GRID_COLS = 20;
  localparam int GRID_ROWS = 15;
  localparam int SHIP_ROW  = 13;
  localparam int LINE_W    = $clog2(GRID_ROWS);

  typedef enum logic [1:0] {
    GP_PLAYING   = 2'b00,
    GP_YOU_WIN   = 2'b01,
    GP_GAME_OVER = 2'b10
  } gameplay_e;

  // 12-bit RGB palette used by the renderer
  localparam logic [11:0] COLOR_BG      = 12'h000;
  localparam logic [11:0] COLOR_SHIP    = 12'h0F0;
  localparam logic [11:0] COLOR_BULLET  = 12'hFF0;
  localparam logic [11:0] COLOR_INVADER = 12'hF0F;
  localparam logic [11:0] COLOR_WIN     = 12'h0FF;
  localparam logic [11:0] COLOR_LOSE    = 12'hF00;

endpackage

// File: rtl/frame_divider.sv
// Frame-tick divider: counts enabled ticks 0..PERIOD-1 and flags the wrapping tick.
module frame_divider #(
  parameter int PERIOD = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_frame_tick,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expire
);

  localparam logic [5:0] LAST = 6'(PERIOD - 1);

  logic [5:0] cnt_q, cnt_d;

  always_comb begin
    o_expire = i_frame_tick && i_enable && !i_clear && (cnt_q == LAST);
    cnt_d    = cnt_q;
    if (i_frame_tick) begin
      if (i_clear)       cnt_d = '0;
      else if (i_enable) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 6'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_state_engine.sv
// Per-frame game state: ship, bullet, invader formation and win/lose tracking,
// all registered and fed straight to the sprite renderer.
//
// state        | meaning
// GP_PLAYING   | game running, all counters and objects advance on each tick
// GP_YOU_WIN   | formation cleared, picture frozen, wait for a fresh fire press
// GP_GAME_OVER | formation reached the ship row, frozen, wait for fire press
module game_state_engine #(
  parameter int          SHIP_PERIOD    = 4,
  parameter int          BULLET_PERIOD  = 2,
  parameter int          INVADER_PERIOD = 30,
  parameter logic [19:0] INIT_ARRAY     = 20'h0FFF0,
  parameter int          INIT_LINE      = 1,
  parameter int          SHIP_ROW       = game_pkg::SHIP_ROW,
  parameter int          SHIP_INIT      = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_frame_tick,
  input  logic        i_left,
  input  logic        i_right,
  input  logic        i_fire,
  output logic [19:0] o_invaders_array,
  output logic [3:0]  o_invaders_line,
  output logic [4:0]  o_ship_x,
  output logic [4:0]  o_bullet_x,
  output logic [3:0]  o_bullet_y,
  output logic        o_bullet_flying,
  output logic [1:0]  o_gameplay
);

  import game_pkg::*;

  logic [GRID_COLS-1:0] array_q, array_d, arr_post;
  logic [LINE_W-1:0]    line_q, line_d;
  logic [4:0]           ship_x_q, ship_x_d;
  logic [4:0]           bullet_x_q, bullet_x_d;
  logic [3:0]           bullet_y_q, bullet_y_d;
  logic                 flying_q, flying_d;
  logic                 dir_right_q, dir_right_d;
  logic                 fire_prev_q, fire_prev_d;
  gameplay_e            gameplay_q, gameplay_d;

  logic playing, restart, hit, edge_hit;
  logic ship_exp, bullet_exp, inv_exp;
  logic ship_clear;

  assign playing    = (gameplay_q == GP_PLAYING);
  assign restart    = i_frame_tick && !playing && i_fire && !fire_prev_q;
  assign hit        = flying_q && (bullet_y_q == line_q) && array_q[bullet_x_q];
  assign ship_clear = !(i_left || i_right) || restart;

  frame_divider #(.PERIOD(SHIP_PERIOD)) u_ship_div (
    .i_clk(i_clk), .i_reset(i_reset), .i_frame_tick(i_frame_tick),
    .i_enable(playing), .i_clear(ship_clear), .o_expire(ship_exp)
  );

  frame_divider #(.PERIOD(BULLET_PERIOD)) u_bullet_div (
    .i_clk(i_clk), .i_reset(i_reset), .i_frame_tick(i_frame_tick),
    .i_enable(playing), .i_clear(restart), .o_expire(bullet_exp)
  );

  frame_divider #(.PERIOD(INVADER_PERIOD)) u_invader_div (
    .i_clk(i_clk), .i_reset(i_reset), .i_frame_tick(i_frame_tick),
    .i_enable(playing), .i_clear(restart), .o_expire(inv_exp)
  );

  always_comb begin
    array_d     = array_q;
    line_d      = line_q;
    ship_x_d    = ship_x_q;
    bullet_x_d  = bullet_x_q;
    bullet_y_d  = bullet_y_q;
    flying_d    = flying_q;
    dir_right_d = dir_right_q;
    fire_prev_d = fire_prev_q;
    gameplay_d  = gameplay_q;
    arr_post    = array_q;
    edge_hit    = 1'b0;

    if (i_frame_tick) begin
      fire_prev_d = i_fire;
      if (playing) begin
        if (hit) begin
          arr_post[bullet_x_q] = 1'b0;
          flying_d             = 1'b0;
        end else if (flying_q && bullet_exp) begin
          if (bullet_y_q == 4'd0) flying_d   = 1'b0;
          else                    bullet_y_d = bullet_y_q - 4'd1;
        end

        // a bullet leaving the screen this tick still blocks a new shot
        if (!flying_q && !hit && i_fire) begin
          bullet_x_d = ship_x_q;
          bullet_y_d = 4'(SHIP_ROW - 1);
          flying_d   = 1'b1;
        end

        if (ship_exp) begin
          if (i_left && !i_right && ship_x_q != 5'd0)
            ship_x_d = ship_x_q - 5'd1;
          else if (i_right && !i_left && ship_x_q != 5'(GRID_COLS - 1))
            ship_x_d = ship_x_q + 5'd1;
        end

        array_d = arr_post;
        if (inv_exp) begin
          edge_hit = dir_right_q ? arr_post[GRID_COLS-1] : arr_post[0];
          if (edge_hit) begin
            line_d      = line_q + 4'd1;
            dir_right_d = !dir_right_q;
          end else if (dir_right_q) begin
            array_d = arr_post << 1;
          end else begin
            array_d = arr_post >> 1;
          end
        end

        if (arr_post == '0)                   gameplay_d = GP_YOU_WIN;
        else if (line_d == 4'(SHIP_ROW))      gameplay_d = GP_GAME_OVER;
      end else if (restart) begin
        array_d     = INIT_ARRAY;
        line_d      = 4'(INIT_LINE);
        ship_x_d    = 5'(SHIP_INIT);
        bullet_x_d  = 5'd0;
        bullet_y_d  = 4'd0;
        flying_d    = 1'b0;
        dir_right_d = 1'b1;
        gameplay_d  = GP_PLAYING;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      array_q     <= INIT_ARRAY;
      line_q      <= 4'(INIT_LINE);
      ship_x_q    <= 5'(SHIP_INIT);
      bullet_x_q  <= 5'd0;
      bullet_y_q  <= 4'd0;
      flying_q    <= 1'b0;
      dir_right_q <= 1'b1;
      fire_prev_q <= 1'b0;
      gameplay_q  <= GP_PLAYING;
    end else begin
      array_q     <= array_d;
      line_q      <= line_d;
      ship_x_q    <= ship_x_d;
      bullet_x_q  <= bullet_x_d;
      bullet_y_q  <= bullet_y_d;
      flying_q    <= flying_d;
      dir_right_q <= dir_right_d;
      fire_prev_q <= fire_prev_d;
      gameplay_q  <= gameplay_d;
    end
  end

  assign o_invaders_array = array_q;
  assign o_invaders_line  = line_q;
  assign o_ship_x         = ship_x_q;
  assign o_bullet_x       = bullet_x_q;
  assign o_bullet_y       = bullet_y_q;
  assign o_bullet_flying  = flying_q;
  assign o_gameplay       = gameplay_q;

endmodule
